// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  // Widest address word_align() handles; callers cast to their own width.
  localparam int unsigned WA_MAX_W  = 64;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  // Force a byte address onto its 32-bit word boundary.
  function automatic logic [WA_MAX_W-1:0] word_align(input logic [WA_MAX_W-1:0] addr);
    return addr & ~WA_MAX_W'(3);
  endfunction

endpackage

// File: rtl/dmem_arb_select.sv
// Grant selection for the two-port data-memory arbiter.
// Default: fixed priority to port 0 with a starvation guard for port 1.
// With DMEM_ARB_ROUND_ROBIN_EN defined: alternating grant via last_grant.
// Requires STARVE_MAX >= 1.
module dmem_arb_select
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic                 accept,
  output logic                 sel_c
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN

  logic last_grant;

  // Lone valid wins; on contention the port other than last_grant wins.
  always_comb begin
    sel_c = req_valid[1];
    if (&req_valid) sel_c = ~last_grant;
  end

  // Remember the last granted port; reset value lets port 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= sel_c;
    end
  end

`else

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  // Port 0 wins unless port 1 has waited out STARVE_MAX grants or is alone.
  always_comb begin
    sel_c = 1'b0;
    if (req_valid[1] && (!req_valid[0] || starve_cnt == CW'(STARVE_MAX))) sel_c = 1'b1;
  end

  // Count port-0 grants taken while port 1 was waiting, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (sel_c || !req_valid[1]) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, word-aligned data memory.
// One transaction: accept (IDLE) -> memory access (ACCESS) -> response (RESP).
// Optional macro DMEM_ARB_ROUND_ROBIN_EN switches selection to round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS-1:0]    req_we,
  input  logic [NUM_PORTS*AW-1:0] req_addr,
  input  logic [NUM_PORTS*DW-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    req_ready,
  output logic [NUM_PORTS-1:0]    rsp_valid,
  output logic [DW-1:0]           rsp_rdata,
  input  logic [NUM_PORTS-1:0]    rsp_ready,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_a,
  output logic [DW-1:0]           mem_wd,
  input  logic [DW-1:0]           mem_rd
);

  arb_state_t    state;
  logic          grant;
  logic          sel_c;
  logic          accept_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;

  dmem_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .accept    (accept_c),
    .sel_c     (sel_c)
  );

  // Payload of the currently selected port.
  always_comb begin
    sel_we_c    = sel_c ? req_we[1]           : req_we[0];
    sel_addr_c  = sel_c ? req_addr[AW +: AW]  : req_addr[0 +: AW];
    sel_wdata_c = sel_c ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
  end

  // Combinational accept: only in IDLE, out of reset, with something valid.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && |req_valid) req_ready[sel_c] = 1'b1;
    accept_c  = |req_ready;
  end

  // Transaction FSM with registered memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            grant  <= sel_c;
            mem_we <= sel_we_c;
            mem_a  <= AW'(word_align(WA_MAX_W'(sel_addr_c)));
            mem_wd <= sel_wdata_c;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // Read data is captured on writes too, giving the pre-write word.
          mem_we           <= 1'b0;
          rsp_rdata        <= mem_rd;
          rsp_valid[grant] <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_we, req_ready, rsp_valid, rsp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wd, mem_rd;
  logic            mem_we;
  logic [AW-1:0]   mem_a;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_ready (rsp_ready),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  // Environment memory: 64 words, combinational read, write on posedge.
  logic [31:0] dmem [64];
  always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = dmem[mem_a[7:2]];

  // Reference model state.
  logic [31:0] ref_mem [logic [31:0]];
  int          streak;
  int          last_grant;

  // Requester state.
  logic [1:0]  pend, pwe;
  logic [31:0] paddr [2];
  logic [31:0] pwd   [2];

  int n_checks;
  int n_pass;
  int seq_exp [10];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive_req();
    req_valid = pend;
    req_we    = pwe;
    req_addr  = {paddr[1], paddr[0]};
    req_wdata = {pwd[1], pwd[0]};
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  // Which port the selection rules pick from the currently pending set.
  function automatic int predict();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (pend[0] && pend[1]) return 1 - last_grant;
    return pend[1] ? 1 : 0;
`else
    if (pend[1] && (!pend[0] || streak == STARVE_MAX)) return 1;
    return 0;
`endif
  endfunction

  task automatic model_accept(input int g);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_grant = g;
`else
    if (g == 1 || !pend[1]) streak = 0;
    else if (streak < STARVE_MAX) streak++;
`endif
  endtask

  task automatic rand_req(input int p);
    pend[p]  = 1'b1;
    pwe[p]   = 1'($urandom_range(0, 1));
    paddr[p] = 32'($urandom_range(0, 127));
    pwd[p]   = $urandom;
  endtask

  // Reset for the given cycles, checking quiet outputs each cycle.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    rsp_ready = 2'b00;
    drive_req();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #2;
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_mem_we", mem_we, 1'b0);
    end
    rst = 1'b0;
    streak = 0;
    last_grant = 1;
  endtask

  // One full transaction; entered and left mid-cycle of an IDLE cycle.
  task automatic run_txn(input int stall, output int g_obs);
    int          exp_g;
    int          wait_n;
    logic [1:0]  oh;
    logic [31:0] aw, exp_rd;
    logic        we;
    g_obs = -1;
    exp_g = predict();
    oh = (exp_g == 1) ? 2'b10 : 2'b01;
    drive_req(); #1;
    wait_n = 0;
    while (req_ready == 2'b00 && wait_n < 20) begin
      @(posedge clk); #2;
      wait_n++;
    end
    if (req_ready == 2'b00) begin
      check("accept_timeout", 1'b0, 1'b1);
      return;
    end
    check("req_ready", req_ready, oh);
    g_obs = (req_ready == 2'b10) ? 1 : 0;
    we = pwe[exp_g];
    aw = paddr[exp_g] & 32'hFFFF_FFFC;
    exp_rd = ref_read(aw);
    model_accept(exp_g);
    @(posedge clk); #1;
    pend[exp_g] = 1'b0;
    drive_req(); #1;
    check("access_we", mem_we, we);
    check("access_addr", mem_a, aw);
    if (we) begin
      check("access_wdata", mem_wd, pwd[exp_g]);
      ref_mem[aw] = pwd[exp_g];
    end
    check("access_no_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rsp_ready = (stall > 0) ? ~oh : oh; #1;
    check("rsp_valid", rsp_valid, oh);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_no_we", mem_we, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (s == stall - 1) rsp_ready = oh;
      #1;
      check("hold_valid", rsp_valid, oh);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_no_ready", req_ready, 2'b00);
      check("hold_no_we", mem_we, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00; #1;
    check("rsp_done", rsp_valid, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int st;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    n_checks = 0;
    n_pass = 0;
    streak = 0;
    last_grant = 1;
    rsp_ready = 2'b00;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    seq_exp = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    seq_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

    // Reset with both ports requesting, then write 0x10 and read back 0x13.
    pend = 2'b11;
    pwe = 2'b01;
    paddr[0] = 32'h10; pwd[0] = 32'hDEAD_BEEF;
    paddr[1] = 32'h40; pwd[1] = 32'h0;
    do_reset(2);
    run_txn(0, g);
    check("first_grant", g, 0);
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 32'h13;
    for (int i = 0; i < 3 && pend != 2'b00; i++) run_txn(0, g);
    check("drained", pend, 2'b00);

    // Continuous contention from a clean reset.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < 2; p++) if (!pend[p]) rand_req(p);
      st = (predict() == 1) ? 5 : 0;
      run_txn(st, g);
      check("contention_seq", g, seq_exp[i]);
    end

    // Reset during the ACCESS cycle of a write to 0x20.
    pend = 2'b00;
    do_reset(1);
    pend = 2'b01; pwe = 2'b01; paddr[0] = 32'h20; pwd[0] = 32'hCAFE_F00D;
    drive_req(); #1;
    check("mid_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    pend = 2'b00;
    drive_req(); #1;
    check("mid_access_we", mem_we, 1'b1);
    rst = 1'b1;
    @(posedge clk); #2;
    ref_mem[32'h20] = 32'hCAFE_F00D;
    check("mid_rsp_valid", rsp_valid, 2'b00);
    check("mid_mem_we", mem_we, 1'b0);
    rst = 1'b0;
    streak = 0;
    last_grant = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("post_rst_rsp_valid", rsp_valid, 2'b00);
      check("post_rst_mem_we", mem_we, 1'b0);
    end
    pend = 2'b01; pwe = 2'b00; paddr[0] = 32'h22;
    run_txn(1, g);

    // Top-of-address-space word.
    pend = 2'b10; pwe = 2'b10; paddr[1] = 32'hFFFF_FFFE; pwd[1] = 32'h1234_5678;
    run_txn(0, g);
    pend = 2'b01; pwe = 2'b00; paddr[0] = 32'hFFFF_FFFC;
    run_txn(2, g);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 1) == 1) rand_req(p);
      if (pend == 2'b00) rand_req(int'($urandom_range(0, 1)));
      run_txn(int'($urandom_range(0, 3)), g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-aligned, big-endian data memory between two requesters: port 0 (core load/store) and port 1 (DMA/debug).
- Registers each accepted request, drives the memory write strobe for exactly one cycle, captures read data, and returns a response through a valid/ready handshake.
- Sits between the requesters and the data memory. The memory reads combinationally and writes on posedge clk.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must equal the memory word width.
- STARVE_MAX, 4, number of consecutive port-0 grants allowed while port 1 waits before port 1 is forced.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-port request valid; bit n is port n.
- req_we  in  2  per-port write flag.
- req_addr  in  2*AW  per-port byte address; port n occupies [n*AW +: AW].
- req_wdata  in  2*DW  per-port write data.
- req_ready  out  2  per-port accept, one-hot or zero.
- rsp_valid  out  2  per-port response valid.
- rsp_rdata  out  DW  read data, shared by both ports and qualified by rsp_valid.
- rsp_ready  in  2  per-port response accept.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data (combinational from mem_a).

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values: state=IDLE, grant=0, starve_cnt=0, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_we=0, mem_a=0, mem_wd=0. Reset mid-transaction abandons it. Any write already strobed stays committed; no response is issued.
- IDLE:
  - req_ready is combinational. It asserts for the selected port only when at least one req_valid is set.
  - On the accept edge, latch we/addr/wdata and the grant index, then go to ACCESS.
- Selection (default, fixed priority):
  - Port 0 wins, except when starve_cnt==STARVE_MAX and req_valid[1]; then port 1 wins.
  - starve_cnt increments when port 0 is granted while req_valid[1]=1, and saturates at STARVE_MAX.
  - starve_cnt clears on any port-1 grant, or when req_valid[1]=0 at an accept.
- ACCESS (one cycle):
  - mem_a={addr[AW-1:2],2'b00}. The low two address bits are dropped silently.
  - mem_wd=latched wdata; mem_we=latched we, asserted only in this cycle.
  - At the clock edge, capture mem_rd into rsp_rdata. This also happens on writes, where it holds the pre-write word.
  - Then go to RESP.
- RESP:
  - rsp_valid[grant]=1 and holds with stable rsp_rdata until rsp_ready[grant]=1. On that edge go to IDLE.
  - Back-to-back requests need IDLE for one cycle, so throughput is one transaction per 3 cycles minimum.
- Latency: accept edge at cycle N → mem_we/mem_a driven in cycle N+1 → rsp_valid high in cycle N+2.
- Boundary and stall rules:
  - Requests arriving outside IDLE are not accepted; req_ready stays 0.
  - Requesters must hold req_valid and payload stable until accepted.
  - Both ports valid in the same cycle: the selection rule decides; the loser waits.
  - rsp_ready on the non-granted port is ignored.
  - mem_we never asserts outside ACCESS.
  - Address 0xFFFFFFFC is legal. Memory wrap-around is the memory's concern.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Selection alternates using a last_grant register (reset 1, so port 0 wins the first contention).
  - On simultaneous valid, the port other than last_grant wins; a lone valid always wins.
  - starve_cnt and STARVE_MAX logic are removed.
- Undefined: fixed priority with the starvation guard, as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t
  - NUM_PORTS=2
  - a function word_align(addr).
- One sub-module is natural: dmem_arb_select. It is the combinational grant logic and contains the starvation counter or round-robin pointer.
- The FSM and datapath registers stay in dmem_arbiter.

Test Plan:
- Reset then idle: rst high 2 cycles with req_valid=2'b11 → req_ready=0, rsp_valid=0, mem_we=0 throughout reset. After release, the first accept is port 0.
- Single write then read, port 0:
  - Write addr 0x10, data 0xDEADBEEF → mem_we=1 for exactly one cycle with mem_a=0x10; rsp_valid[0] at N+2.
  - Read 0x13 → mem_a=0x10, rsp_rdata=0xDEADBEEF.
- Contention, default build: both ports valid continuously → grant sequence is 0,0,0,0,1,0,0,0,0,1 (STARVE_MAX=4).
- Contention with DMEM_ARB_ROUND_ROBIN_EN: both ports valid continuously → grants alternate 0,1,0,1.
- Response backpressure: rsp_ready[1] held low 5 cycles → rsp_valid[1] and rsp_rdata stable; no new accept on either port until the handshake.
- Reset mid-ACCESS on a write to 0x20: rst asserts in the ACCESS cycle → state=IDLE next cycle, rsp_valid stays 0, and no further mem_we pulses.
